// File: rtl/vec_sequencer.sv
// vec_sequencer: replays a stored table of stimulus vectors into a DUT and checks
// the DUT responses one cycle later against a table of expected responses.
// It counts mismatches, records the first failing index and compresses every
// captured response into a MISR signature. Loop mode repeats passes until abort.
module vec_sequencer #(
    parameter int IN_W  = 33,
    parameter int OUT_W = 25,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH),
    parameter logic [OUT_W-1:0] POLY = 25'h0000009
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_stim,
    input  logic             ld_exp,
    input  logic [AW-1:0]    ld_addr,
    input  logic [IN_W-1:0]  ld_stim_data,
    input  logic [OUT_W-1:0] ld_exp_data,
    input  logic             start,
    input  logic             loop_mode,
    input  logic             abort,
    input  logic [AW:0]      num_vec,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [15:0]      mismatch_cnt,
    output logic [AW-1:0]    first_fail_idx,
    output logic             first_fail_vld,
    output logic [OUT_W-1:0] signature,
    output logic [7:0]       pass_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state;
    state_t next_state;

    logic [IN_W-1:0]  stim_mem [DEPTH];
    logic [OUT_W-1:0] exp_mem  [DEPTH];

    logic [AW-1:0]    idx;
    logic [AW-1:0]    idx_d;
    logic [AW:0]      nv;
    logic             loop_q;
    logic             cap_vld;

    logic             apply;
    logic             last_idx;
    logic             miscompare;
    logic [AW:0]      nv_clamped;
    logic [OUT_W-1:0] sig_next;

    assign busy = (state != IDLE);

    // Memories are written only while idle; their contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && state == IDLE) begin
            if (ld_stim) begin
                stim_mem[ld_addr] <= ld_stim_data;
            end
            if (ld_exp) begin
                exp_mem[ld_addr] <= ld_exp_data;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus the per-cycle apply/capture decisions.
    always_comb begin
        next_state = state;
        nv_clamped = (num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_vec;
        last_idx   = ({1'b0, idx} == (nv - 1'b1));
        apply      = (state == RUN) && !abort;
        miscompare = cap_vld && (dut_out != exp_mem[idx_d]);
        sig_next   = {signature[OUT_W-2:0], 1'b0}
                   ^ (signature[OUT_W-1] ? POLY : '0)
                   ^ dut_out;
        case (state)
            IDLE: begin
                if (start && num_vec != '0) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (abort || (last_idx && !loop_q)) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: run setup, vector apply stage, one-cycle-late capture stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            dut_in         <= '0;
            done           <= 1'b0;
            aborted        <= 1'b0;
            mismatch_cnt   <= '0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
            signature      <= '0;
            pass_cnt       <= '0;
            idx            <= '0;
            idx_d          <= '0;
            nv             <= '0;
            loop_q         <= 1'b0;
            cap_vld        <= 1'b0;
        end else begin
            done    <= 1'b0;
            cap_vld <= apply;
            if (state == IDLE && start) begin
                mismatch_cnt   <= '0;
                first_fail_vld <= 1'b0;
                first_fail_idx <= '0;
                signature      <= '0;
                pass_cnt       <= '0;
                aborted        <= 1'b0;
                idx            <= '0;
                nv             <= nv_clamped;
                loop_q         <= loop_mode;
                if (num_vec == '0) begin
                    done <= 1'b1;
                end
            end
            if (cap_vld) begin
                signature <= sig_next;
                if (miscompare) begin
                    if (mismatch_cnt != 16'hFFFF) begin
                        mismatch_cnt <= mismatch_cnt + 16'd1;
                    end
                    if (!first_fail_vld) begin
                        first_fail_idx <= idx_d;
                        first_fail_vld <= 1'b1;
                    end
                end
            end
            if (apply) begin
                dut_in <= stim_mem[idx];
                idx_d  <= idx;
                if (last_idx) begin
                    idx      <= '0;
                    pass_cnt <= pass_cnt + 8'd1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
            if (state == RUN && abort) begin
                aborted <= 1'b1;
            end
            if (state == DRAIN) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vec_sequencer.sv
// Testbench for vec_sequencer: a directed table of runs, hand-written corner
// sequences (reset mid-run, loads while busy, load together with start) and a
// randomized section, all checked against a behavioural model of a run.
module tb_vec_sequencer;

    localparam int IN_W  = 33;
    localparam int OUT_W = 25;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam logic [OUT_W-1:0] POLY = 25'h0000009;

    logic             clk = 1'b0;
    logic             rst;
    logic             ld_stim;
    logic             ld_exp;
    logic [AW-1:0]    ld_addr;
    logic [IN_W-1:0]  ld_stim_data;
    logic [OUT_W-1:0] ld_exp_data;
    logic             start;
    logic             loop_mode;
    logic             abort;
    logic [AW:0]      num_vec;
    logic [IN_W-1:0]  dut_in;
    logic [OUT_W-1:0] dut_out;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [15:0]      mismatch_cnt;
    logic [AW-1:0]    first_fail_idx;
    logic             first_fail_vld;
    logic [OUT_W-1:0] signature;
    logic [7:0]       pass_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [IN_W-1:0]  stim_ref [DEPTH];
    logic [OUT_W-1:0] exp_ref  [DEPTH];
    logic [IN_W-1:0]  exp_dut_in;

    typedef struct {
        int nv;
        bit lp;
        int abort_r;
        int exp_pass;
        bit exp_abt;
        int exp_done;
    } vec_t;

    vec_t table_v [10];

    vec_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .ld_stim        (ld_stim),
        .ld_exp         (ld_exp),
        .ld_addr        (ld_addr),
        .ld_stim_data   (ld_stim_data),
        .ld_exp_data    (ld_exp_data),
        .start          (start),
        .loop_mode      (loop_mode),
        .abort          (abort),
        .num_vec        (num_vec),
        .dut_in         (dut_in),
        .dut_out        (dut_out),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted),
        .mismatch_cnt   (mismatch_cnt),
        .first_fail_idx (first_fail_idx),
        .first_fail_vld (first_fail_vld),
        .signature      (signature),
        .pass_cnt       (pass_cnt)
    );

    // The device under test is a plain wire loop from stimulus to response.
    assign dut_out = dut_in[OUT_W-1:0];

    always #5 clk = ~clk;

    // Hard stop in case something stalls outside the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference run: walk the vector list implied by num_vec, loop and abort timing.
    task automatic refModel(input int nv, input bit lp, input int abort_r,
                            output logic [OUT_W-1:0] sig, output int mism,
                            output int ffidx, output bit ffvld, output int pass,
                            output bit abt, output int done_edges);
        int nvc;
        int applied;
        int i;
        logic [OUT_W-1:0] r;
        nvc = (nv > DEPTH) ? DEPTH : nv;
        sig = '0; mism = 0; ffidx = 0; ffvld = 0; pass = 0; abt = 0;
        if (nvc == 0) begin
            done_edges = 1;
            return;
        end
        abt        = (abort_r >= 0) && (lp || (abort_r + 1 <= nvc));
        applied    = abt ? abort_r : nvc;
        done_edges = abt ? abort_r + 3 : nvc + 2;
        pass       = applied / nvc;
        for (int k = 0; k < applied; k++) begin
            i   = k % nvc;
            r   = stim_ref[i][OUT_W-1:0];
            sig = {sig[OUT_W-2:0], 1'b0} ^ (sig[OUT_W-1] ? POLY : '0) ^ r;
            if (r !== exp_ref[i]) begin
                mism++;
                if (!ffvld) begin
                    ffvld = 1'b1;
                    ffidx = i;
                end
            end
        end
        if (applied > 0) begin
            exp_dut_in = stim_ref[(applied - 1) % nvc];
        end
    endtask

    task automatic loadOne(input int addr, input logic [IN_W-1:0] s, input logic [OUT_W-1:0] e,
                           input bit ws, input bit we);
        @(negedge clk);
        ld_stim      = ws;
        ld_exp       = we;
        ld_addr      = AW'(addr);
        ld_stim_data = s;
        ld_exp_data  = e;
        if (ws) stim_ref[addr] = s;
        if (we) exp_ref[addr] = e;
        @(posedge clk);
        #1;
        ld_stim = 1'b0;
        ld_exp  = 1'b0;
    endtask

    // Runs one start..done sequence and checks every result output against the model.
    // ld_at = 0 writes stim[0] together with start; ld_at > 0 attempts a write while busy.
    task automatic applyStimulus(input string name, input int nv, input bit lp, input int abort_r,
                                 input int ld_at, input logic [IN_W-1:0] ld_data,
                                 output int done_edges);
        int edges;
        bit saw_busy;
        logic [OUT_W-1:0] m_sig;
        int m_mism, m_ffidx, m_pass, m_done;
        bit m_ffvld, m_abt;
        @(negedge clk);
        start     = 1'b1;
        num_vec   = (AW+1)'(nv);
        loop_mode = lp;
        if (ld_at == 0) begin
            ld_stim      = 1'b1;
            ld_addr      = '0;
            ld_stim_data = ld_data;
            stim_ref[0]  = ld_data;
        end
        edges      = 0;
        done_edges = -1;
        saw_busy   = 1'b0;
        while (edges < 300 && done_edges < 0) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            start   = 1'b0;
            ld_stim = 1'b0;
            ld_exp  = 1'b0;
            abort   = (abort_r >= 0) && (edges == abort_r + 1);
            if (ld_at > 0 && edges == ld_at) begin
                ld_stim      = 1'b1;
                ld_exp       = 1'b1;
                ld_addr      = AW'(3);
                ld_stim_data = ld_data;
                ld_exp_data  = '1;
            end
            if (busy) saw_busy = 1'b1;
            if (done) done_edges = edges;
        end
        abort   = 1'b0;
        ld_stim = 1'b0;
        ld_exp  = 1'b0;
        refModel(nv, lp, abort_r, m_sig, m_mism, m_ffidx, m_ffvld, m_pass, m_abt, m_done);
        checkOutput({name, ".done_latency"}, 64'(done_edges), 64'(m_done));
        checkOutput({name, ".busy_seen"}, 64'(saw_busy), 64'(nv != 0));
        checkOutput({name, ".mismatch_cnt"}, 64'(mismatch_cnt), 64'(m_mism));
        checkOutput({name, ".first_fail_vld"}, 64'(first_fail_vld), 64'(m_ffvld));
        checkOutput({name, ".first_fail_idx"}, 64'(first_fail_idx), 64'(m_ffidx));
        checkOutput({name, ".signature"}, 64'(signature), 64'(m_sig));
        checkOutput({name, ".pass_cnt"}, 64'(pass_cnt), 64'(m_pass));
        checkOutput({name, ".aborted"}, 64'(aborted), 64'(m_abt));
        checkOutput({name, ".dut_in_hold"}, 64'(dut_in), 64'(exp_dut_in));
        @(negedge clk);
        checkOutput({name, ".done_one_cycle"}, 64'(done), 64'(0));
    endtask

    initial begin
        int de;
        bit saw;
        logic [IN_W-1:0] s;

        rst = 1'b1; ld_stim = 1'b0; ld_exp = 1'b0; ld_addr = '0;
        ld_stim_data = '0; ld_exp_data = '0; start = 1'b0; loop_mode = 1'b0;
        abort = 1'b0; num_vec = '0;
        exp_dut_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        checkOutput("reset.busy", 64'(busy), 64'(0));
        checkOutput("reset.done", 64'(done), 64'(0));
        checkOutput("reset.aborted", 64'(aborted), 64'(0));
        checkOutput("reset.mismatch_cnt", 64'(mismatch_cnt), 64'(0));
        checkOutput("reset.first_fail_idx", 64'(first_fail_idx), 64'(0));
        checkOutput("reset.first_fail_vld", 64'(first_fail_vld), 64'(0));
        checkOutput("reset.signature", 64'(signature), 64'(0));
        checkOutput("reset.pass_cnt", 64'(pass_cnt), 64'(0));
        checkOutput("reset.dut_in", 64'(dut_in), 64'(0));

        for (int i = 0; i < DEPTH; i++) begin
            loadOne(i, IN_W'(i), OUT_W'(i), 1'b1, 1'b1);
        end

        table_v[0] = '{64,  1'b0, -1, 1, 1'b0, 66};
        table_v[1] = '{0,   1'b0, -1, 0, 1'b0, 1};
        table_v[2] = '{100, 1'b0, -1, 1, 1'b0, 66};
        table_v[3] = '{4,   1'b1, 10, 2, 1'b1, 13};
        table_v[4] = '{8,   1'b0, 7,  0, 1'b1, 10};
        table_v[5] = '{5,   1'b0, 5,  1, 1'b0, 7};
        table_v[6] = '{1,   1'b0, -1, 1, 1'b0, 3};
        table_v[7] = '{3,   1'b1, 0,  0, 1'b1, 3};
        table_v[8] = '{4,   1'b1, 8,  2, 1'b1, 11};
        table_v[9] = '{4,   1'b1, 7,  1, 1'b1, 10};

        for (int t = 0; t < 10; t++) begin
            applyStimulus($sformatf("table%0d", t), table_v[t].nv, table_v[t].lp,
                          table_v[t].abort_r, -1, '0, de);
            checkOutput($sformatf("table%0d.exp_done", t), 64'(de), 64'(table_v[t].exp_done));
            checkOutput($sformatf("table%0d.exp_pass", t), 64'(pass_cnt), 64'(table_v[t].exp_pass));
            checkOutput($sformatf("table%0d.exp_abt", t), 64'(aborted), 64'(table_v[t].exp_abt));
        end

        loadOne(17, IN_W'(17), 25'h1ABCDEF, 1'b0, 1'b1);
        loadOne(40, IN_W'(40), 25'h0000041, 1'b0, 1'b1);
        applyStimulus("corrupt", 64, 1'b0, -1, -1, '0, de);
        checkOutput("corrupt.mismatch_two", 64'(mismatch_cnt), 64'(2));
        checkOutput("corrupt.first_idx_17", 64'(first_fail_idx), 64'(17));
        checkOutput("corrupt.first_vld", 64'(first_fail_vld), 64'(1));

        // Reset in the middle of a run, with start held during reset.
        @(negedge clk);
        start = 1'b1; num_vec = 7'd64; loop_mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        checkOutput("midrst.busy", 64'(busy), 64'(0));
        checkOutput("midrst.done", 64'(done), 64'(0));
        checkOutput("midrst.aborted", 64'(aborted), 64'(0));
        checkOutput("midrst.mismatch_cnt", 64'(mismatch_cnt), 64'(0));
        checkOutput("midrst.first_fail_vld", 64'(first_fail_vld), 64'(0));
        checkOutput("midrst.signature", 64'(signature), 64'(0));
        checkOutput("midrst.pass_cnt", 64'(pass_cnt), 64'(0));
        checkOutput("midrst.dut_in", 64'(dut_in), 64'(0));
        saw = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy) saw = 1'b1;
        end
        checkOutput("midrst.quiet_after", 64'(saw), 64'(0));
        exp_dut_in = '0;
        applyStimulus("after_rst", 64, 1'b0, -1, -1, '0, de);

        // Writes attempted while busy must be dropped; rerun confirms memory intact.
        applyStimulus("busy_ld", 16, 1'b0, -1, 5, 33'h1_2345_6789, de);
        applyStimulus("busy_ld_rerun", 16, 1'b0, -1, -1, '0, de);
        applyStimulus("busy_ld_loop", 6, 1'b1, 14, 3, 33'h0_DEAD_BEEF, de);
        applyStimulus("busy_ld_loop_rerun", 6, 1'b0, -1, -1, '0, de);

        // Write to stim[0] in the same cycle as start: the run sees the new value.
        applyStimulus("ld_with_start", 3, 1'b0, -1, 0, 33'h1_5555_AAAA, de);

        for (int it = 0; it < 20; it++) begin
            int nv;
            bit lp;
            int ar;
            if (it % 4 == 0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    s = {1'($urandom_range(0, 1)), 32'($urandom)};
                    loadOne(i, s, ($urandom_range(0, 5) == 0) ? OUT_W'($urandom) : s[OUT_W-1:0],
                            1'b1, 1'b1);
                end
            end
            nv = $urandom_range(0, 80);
            lp = 1'($urandom_range(0, 1));
            if (lp) begin
                ar = $urandom_range(0, 40);
            end else begin
                ar = ($urandom_range(0, 1) == 1) ? $urandom_range(0, nv + 2) : -1;
            end
            applyStimulus($sformatf("rand%0d", it), nv, lp, ar, -1, '0, de);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/vec_sequencer.md
VEC_SEQUENCER -- requirements
Module: vec_sequencer

Interface
REQ-001 Parameter IN_W, default 33, width of each stimulus vector.
REQ-002 Parameter OUT_W, default 25, width of each DUT response.
REQ-003 Parameter DEPTH, default 64, number of entries in the stimulus memory and in the expected-response memory.
REQ-004 Parameter AW, default $clog2(DEPTH), address and count width.
REQ-005 Parameter POLY, default 25'h0000009, MISR feedback polynomial, OUT_W bits.
REQ-006 Port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-007 Port rst, input, 1 bit, synchronous, active-high reset.
REQ-008 Port ld_stim, input, 1 bit, stimulus-memory write strobe.
REQ-009 Port ld_exp, input, 1 bit, expected-memory write strobe.
REQ-010 Port ld_addr, input, AW bits, write address for both memories.
REQ-011 Port ld_stim_data, input, IN_W bits, stimulus write data.
REQ-012 Port ld_exp_data, input, OUT_W bits, expected-response write data.
REQ-013 Port start, input, 1 bit, one-cycle run request.
REQ-014 Port loop_mode, input, 1 bit, sampled at start; 1 means repeat passes until abort.
REQ-015 Port abort, input, 1 bit, stop request.
REQ-016 Port num_vec, input, AW+1 bits, sampled at start; number of vectors per pass.
REQ-017 Port dut_in, output, IN_W bits, vector driven to the DUT.
REQ-018 Port dut_out, input, OUT_W bits, combinational DUT response.
REQ-019 Port busy, output, 1 bit, high in RUN and DRAIN.
REQ-020 Port done, output, 1 bit, one-cycle pulse on entry to IDLE after a run.
REQ-021 Port aborted, output, 1 bit, set when the last run ended by abort.
REQ-022 Port mismatch_cnt, output, 16 bits, saturating count of compare failures.
REQ-023 Port first_fail_idx, output, AW bits, index of the first failing vector.
REQ-024 Port first_fail_vld, output, 1 bit, high once first_fail_idx is valid.
REQ-025 Port signature, output, OUT_W bits, MISR signature of all captured responses.
REQ-026 Port pass_cnt, output, 8 bits, completed passes, wraps at 255 to 0.

Function
REQ-027 FSM states are IDLE, RUN, DRAIN.
- IDLE to RUN on start when num_vec is nonzero.
- RUN to DRAIN after the last index of a non-loop pass, or on abort.
- DRAIN to IDLE after one cycle.
REQ-028 start with num_vec=0 stays in IDLE, pulses done on the next cycle, and leaves counters at zero.
REQ-029 num_vec greater than DEPTH is clamped to DEPTH at start.
REQ-030 At start, the block clears mismatch_cnt, first_fail_vld, first_fail_idx, signature, pass_cnt and aborted, and sets idx=0.
REQ-031 In RUN, each cycle registers dut_in <= stim[idx], then advances idx.
REQ-032 Capture latency is 1 cycle: the vector applied at edge k is compared and compressed at edge k+1.
REQ-033 In RUN, the capture stage compares dut_out against exp[idx_d], where idx_d is idx delayed one cycle.
REQ-034 A capture with dut_out not equal to exp increments mismatch_cnt, saturating at 16'hFFFF.
REQ-035 On the first mismatch only, the block sets first_fail_idx=idx_d and first_fail_vld=1.
REQ-036 Each capture updates the MISR: sig <= (sig<<1) ^ (sig[OUT_W-1] ? POLY : 0) ^ dut_out.
REQ-037 DRAIN performs the final outstanding capture and applies no new vector.
REQ-038 In loop mode, idx wraps from num_vec-1 to 0 and pass_cnt increments on the wrap; captures are continuous across the wrap.
REQ-039 In non-loop mode, pass_cnt increments once on completion.
REQ-040 abort in RUN sets aborted=1 and enters DRAIN; the vector already applied is still captured.
REQ-041 abort in IDLE or DRAIN is ignored.
REQ-042 When abort coincides with the final index, the block sets aborted=1, enters DRAIN, and does not increment pass_cnt.
REQ-043 start while busy is ignored.
REQ-044 ld_stim and ld_exp are honoured only in IDLE and are dropped while busy.
REQ-045 start and a load strobe in the same IDLE cycle: the write completes first, and the run sees the new data.
REQ-046 dut_in holds its last applied vector in IDLE and DRAIN.
REQ-047 Memory contents are not reset.

Reset
REQ-048 rst forces state=IDLE, dut_in=0, busy=0, done=0, aborted=0, mismatch_cnt=0, first_fail_idx=0, first_fail_vld=0, signature=0, pass_cnt=0 and idx=0.
REQ-049 rst during RUN or DRAIN abandons the run with no done pulse; reset wins over all simultaneous inputs.

Verification
REQ-050 Load stim[i]=i and exp[i]=i[24:0] for i=0..63, loop DUT as dut_out=dut_in[24:0], start with num_vec=64 -> done exactly 66 cycles after start, mismatch_cnt=0, first_fail_vld=0, pass_cnt=1.
REQ-051 Same setup with exp[17] corrupted and exp[40] corrupted -> mismatch_cnt=2, first_fail_idx=17, first_fail_vld=1.
REQ-052 num_vec=0 -> no busy, done one cycle after start; num_vec=100 -> 64 vectors applied.
REQ-053 loop_mode=1, num_vec=4, abort after 10 RUN cycles -> pass_cnt=2, aborted=1, 10 captures in the MISR, matching the reference-model signature.
REQ-054 rst asserted mid-RUN -> all outputs at their REQ-048 values next cycle; a new start runs cleanly.
REQ-055 ld_stim issued while busy -> memory unchanged, as verified by a rerun producing an identical signature.
